// File: rtl/pe_model_pkg.sv
// Shared types and helpers for the behavioural PE model: FSM states,
// control-word field layout and a signed saturating adder.
package pe_model_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    WB      = 2'd3
  } state_t;

  localparam int unsigned SAT_CALC_W = 64;

  // Control word layout, MSB to LSB: {pe_id, valid, namespace_id}
  function automatic int unsigned ctrl_width(input int unsigned pe_w, input int unsigned ns_w);
    return pe_w + 1 + ns_w;
  endfunction

  function automatic int unsigned ctrl_valid_pos(input int unsigned ns_w);
    return ns_w;
  endfunction

  function automatic int unsigned ctrl_pe_lsb(input int unsigned ns_w);
    return ns_w + 1;
  endfunction

  // Operands arrive sign-extended to SAT_CALC_W; result clamps to a w-bit signed range
  function automatic logic [SAT_CALC_W-1:0] sat_add(input logic [SAT_CALC_W-1:0] a,
                                                    input logic [SAT_CALC_W-1:0] b,
                                                    input int unsigned w);
    logic signed [SAT_CALC_W-1:0] sum;
    logic signed [SAT_CALC_W-1:0] max_v;
    logic signed [SAT_CALC_W-1:0] min_v;
    sum   = $signed(a) + $signed(b);
    max_v = $signed((SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1));
    min_v = -max_v - SAT_CALC_W'(1);
    if (sum > max_v) return max_v;
    if (sum < min_v) return min_v;
    return sum;
  endfunction

endpackage

// File: rtl/pe_acc_bank.sv
// Per-namespace accumulator array with synchronous clear and a single read port.
// Saturating accumulation when PE_MODEL_SATURATE_EN is defined, wrapping otherwise.
module pe_acc_bank
  import pe_model_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned NUM_NAMESPACES  = 4,
  parameter int unsigned NAMESPACE_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       we,
  input  logic [NAMESPACE_WIDTH-1:0] ns,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic [NAMESPACE_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]      rd_data
);

  logic [DATA_WIDTH-1:0] acc [NUM_NAMESPACES];

  function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef PE_MODEL_SATURATE_EN
    return DATA_WIDTH'(sat_add(SAT_CALC_W'($signed(a)), SAT_CALC_W'($signed(b)), DATA_WIDTH));
`else
    return a + b;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NAMESPACES; i++) acc[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_NAMESPACES; i++) acc[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_NAMESPACES; i++) begin
        if (ns == NAMESPACE_WIDTH'(i)) acc[i] <= acc_add(acc[i], din);
      end
    end
  end

  // Read mux; indices beyond the array read as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_NAMESPACES; i++) begin
      if (rd_idx == NAMESPACE_WIDTH'(i)) rd_data = acc[i];
    end
  end

endmodule

// File: rtl/pe_model_multi.sv
// Behavioural compute-PE stand-in: load / fixed-latency compute / flow-controlled writeback.
// Define PE_MODEL_SATURATE_EN for signed saturating accumulation (wraps by default).
module pe_model_multi
  import pe_model_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned PE_ID           = 0,
  parameter int          PE_INDEX        = 0,
  parameter int unsigned NAMESPACE_WIDTH = 2,
  parameter int unsigned PE_ID_WIDTH     = 2,
  parameter int unsigned NUM_NAMESPACES  = 4,
  parameter int unsigned LOAD_COUNT      = 4,
  parameter int unsigned COMPUTE_CYCLES  = 3,
  parameter int unsigned CTRL_PE_WIDTH   = ctrl_width(PE_ID_WIDTH, NAMESPACE_WIDTH)
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     START,
  input  logic [CTRL_PE_WIDTH-1:0] CTRL_PE,
  input  logic [DATA_WIDTH-1:0]    data_input,
  input  logic                     DATA_IO_DIR,
  output logic [DATA_WIDTH-1:0]    data_output,
  output logic                     DATA_INOUT_WB,
  output logic                     EOI,
  output logic                     EOC,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int unsigned VALID_POS = ctrl_valid_pos(NAMESPACE_WIDTH);
  localparam int unsigned PE_LSB    = ctrl_pe_lsb(NAMESPACE_WIDTH);
  localparam int unsigned LC_W      = $clog2(LOAD_COUNT + 1);
  localparam int unsigned CC_W      = $clog2(COMPUTE_CYCLES + 1);

  if (NUM_NAMESPACES < 1 || NUM_NAMESPACES > (1 << NAMESPACE_WIDTH) || LOAD_COUNT < 1 ||
      COMPUTE_CYCLES < 1 || PE_INDEX < 0 ||
      CTRL_PE_WIDTH != ctrl_width(PE_ID_WIDTH, NAMESPACE_WIDTH)) begin : g_bad_params
    $error("pe_model_multi: illegal parameter combination");
  end

  state_t                     state;
  logic [LC_W-1:0]            load_cnt;
  logic [CC_W-1:0]            comp_cnt;
  logic [NAMESPACE_WIDTH-1:0] wb_idx;

  logic [NAMESPACE_WIDTH-1:0] ns;
  logic [PE_ID_WIDTH-1:0]     pe;
  logic                       valid;
  logic                       accept;
  logic                       in_range;
  logic                       load_done;
  logic                       acc_clear;
  logic [DATA_WIDTH-1:0]      rd_data;

  assign ns        = CTRL_PE[NAMESPACE_WIDTH-1:0];
  assign valid     = CTRL_PE[VALID_POS];
  assign pe        = CTRL_PE[PE_LSB +: PE_ID_WIDTH];
  assign accept    = valid && (pe == PE_ID_WIDTH'(PE_ID)) && (state == LOAD);
  assign in_range  = 32'(ns) < NUM_NAMESPACES;
  assign load_done = (32'(load_cnt) + 32'd1) == LOAD_COUNT;
  assign acc_clear = (state == IDLE) && START;

  pe_acc_bank #(
    .DATA_WIDTH      (DATA_WIDTH),
    .NUM_NAMESPACES  (NUM_NAMESPACES),
    .NAMESPACE_WIDTH (NAMESPACE_WIDTH)
  ) u_acc_bank (
    .clk     (ACLK),
    .rst     (ARESET),
    .clear   (acc_clear),
    .we      (accept && in_range),
    .ns      (ns),
    .din     (data_input),
    .rd_idx  (wb_idx),
    .rd_data (rd_data)
  );

  // Writeback handshake mirrors host readiness directly
  assign data_output   = (state == WB) ? rd_data : '0;
  assign DATA_INOUT_WB = (state == WB) && DATA_IO_DIR;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      load_cnt <= '0;
      comp_cnt <= '0;
      wb_idx   <= '0;
      EOI      <= 1'b0;
      EOC      <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      EOI <= 1'b0;
      EOC <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state    <= LOAD;
            BUSY     <= 1'b1;
            ERR      <= 1'b0;
            load_cnt <= '0;
            comp_cnt <= '0;
            wb_idx   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (!in_range) ERR <= 1'b1;
            load_cnt <= load_cnt + LC_W'(1);
            if (load_done) begin
              state    <= COMPUTE;
              EOI      <= 1'b1;
              comp_cnt <= '0;
            end
          end
        end
        COMPUTE: begin
          if (32'(comp_cnt) == COMPUTE_CYCLES - 1) begin
            state <= WB;
            EOC   <= 1'b1;
          end else begin
            comp_cnt <= comp_cnt + CC_W'(1);
          end
        end
        WB: begin
          if (DATA_IO_DIR) begin
            if (wb_idx == NAMESPACE_WIDTH'(NUM_NAMESPACES - 1)) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              wb_idx <= wb_idx + NAMESPACE_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SIMULATION
  always_ff @(posedge ACLK) begin
    if (!ARESET && accept)
      $display("pe_model_multi[%0d] pe_id=%0d ns=%0d data=%h", PE_INDEX, PE_ID, ns, data_input);
  end
`endif

endmodule

// File: tb/tb_pe_model_multi.sv
// Directed bench for pe_model_multi: a 4-namespace and a 3-namespace instance share stimulus;
// expected writeback words are queued when the load phase completes.
module tb_pe_model_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ctrl;
  logic [15:0] din;
  logic        dir;

  logic [15:0] dout0, dout3;
  logic        wb0, wb3, eoi0, eoi3, eoc0, eoc3, busy0, busy3, err0, err3;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m0 [4];
  logic [15:0] m3 [4];
  logic        err3_exp;
  logic        loading;
  int          acc_cnt;
  logic [15:0] q0 [$];
  logic [15:0] q3 [$];

  always #5 clk = ~clk;

  pe_model_multi u_dut0 (
    .ACLK (clk), .ARESET (rst), .START (start), .CTRL_PE (ctrl), .data_input (din),
    .DATA_IO_DIR (dir), .data_output (dout0), .DATA_INOUT_WB (wb0), .EOI (eoi0),
    .EOC (eoc0), .BUSY (busy0), .ERR (err0)
  );

  pe_model_multi #(.NUM_NAMESPACES(3), .PE_INDEX(1)) u_dut3 (
    .ACLK (clk), .ARESET (rst), .START (start), .CTRL_PE (ctrl), .data_input (din),
    .DATA_IO_DIR (dir), .data_output (dout3), .DATA_INOUT_WB (wb3), .EOI (eoi3),
    .EOC (eoc3), .BUSY (busy3), .ERR (err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
`ifdef PE_MODEL_SATURATE_EN
    logic signed [16:0] s;
    s = $signed({a[15], a}) + $signed({b[15], b});
    if (s > 17'sd32767) return 16'h7FFF;
    if (s < -17'sd32768) return 16'h8000;
    return s[15:0];
`else
    return a + b;
`endif
  endfunction

  task automatic wr(input logic [1:0] pe, input logic [1:0] ns, input logic [15:0] d);
    ctrl = {pe, 1'b1, ns};
    din  = d;
    if (loading && pe == 2'd0) begin
      m0[ns] = m_add(m0[ns], d);
      if (ns < 2'd3) m3[ns] = m_add(m3[ns], d);
      else err3_exp = 1'b1;
      acc_cnt++;
      if (acc_cnt == 4) begin
        loading = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back(m0[i]);
        for (int i = 0; i < 3; i++) q3.push_back(m3[i]);
      end
    end
    @(posedge clk);
    #1;
    ctrl[2] = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m0[i] = 16'h0;
      m3[i] = 16'h0;
    end
    loading  = 1'b1;
    acc_cnt  = 0;
    err3_exp = 1'b0;
    check("start_busy0", 32'(busy0), 32'd1);
    check("start_busy3", 32'(busy3), 32'd1);
    check("start_err0", 32'(err0), 32'd0);
    check("start_err3", 32'(err3), 32'd0);
  endtask

  // Entered in the cycle right after the last accepted write; leaves in the first WB cycle
  task automatic check_eoi_eoc();
    check("eoi0", 32'(eoi0), 32'd1);
    check("eoi3", 32'(eoi3), 32'd1);
    check("eoc0_early", 32'(eoc0), 32'd0);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      check("eoi0_off", 32'(eoi0), 32'd0);
      check("eoc0", 32'(eoc0), (j == 3) ? 32'd1 : 32'd0);
      check("eoc3", 32'(eoc3), (j == 3) ? 32'd1 : 32'd0);
    end
    check("err0", 32'(err0), 32'd0);
    check("err3", 32'(err3), 32'(err3_exp));
  endtask

  task automatic drain(input logic [7:0] pat, input int n);
    int   k = 0;
    bit   done = 0;
    logic p0, p3;
    while (!done) begin
      dir = (k < n) ? pat[k] : 1'b1;
      #1;
      p0 = dir && (q0.size() > 0);
      p3 = dir && (q3.size() > 0);
      check("wb0_valid", 32'(wb0), 32'(p0));
      check("wb3_valid", 32'(wb3), 32'(p3));
      check("wb0_busy", 32'(busy0), (q0.size() > 0) ? 32'd1 : 32'd0);
      if (q0.size() > 0) check("wb0_data", 32'(dout0), 32'(q0[0]));
      else check("wb0_data_idle", 32'(dout0), 32'd0);
      if (q3.size() > 0) check("wb3_data", 32'(dout3), 32'(q3[0]));
      else check("wb3_data_idle", 32'(dout3), 32'd0);
      if (k > 0) check("wb_eoc0", 32'(eoc0), 32'd0);
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p3) void'(q3.pop_front());
      #1;
      k++;
      if (q0.size() == 0 && q3.size() == 0) done = 1;
      else if (k > n + 12) begin
        check("wb_timeout", 32'(q0.size() + q3.size()), 32'd0);
        done = 1;
      end
    end
    dir = 1'b0;
    #1;
    check("wb_end_busy0", 32'(busy0), 32'd0);
    check("wb_end_busy3", 32'(busy3), 32'd0);
    check("wb_end_valid0", 32'(wb0), 32'd0);
    check("wb_end_data0", 32'(dout0), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ctrl = '0; din = '0; dir = 1'b0;
    loading = 1'b0; acc_cnt = 0; err3_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_eoi0", 32'(eoi0), 32'd0);
    check("rst_eoc0", 32'(eoc0), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_wb0", 32'(wb0), 32'd0);
    check("rst_dout0", 32'(dout0), 32'd0);

    // Pass 1: one write of 1 per namespace; ns 3 is out of range for the 3-namespace build
    do_start();
    for (int i = 0; i < 4; i++) wr(2'd0, 2'(i), 16'h0001);
    check_eoi_eoc();
    drain(8'h00, 0);

    // Pass 2: foreign pe_id writes interleaved, only PE 0 writes count; stalling writeback
    do_start();
    for (int i = 0; i < 4; i++) begin
      wr(2'd1, 2'd0, 16'h0010);
      check("eoi0_foreign", 32'(eoi0), 32'd0);
      wr(2'd0, 2'd0, 16'h0010);
      if (i < 3) check("eoi0_mid", 32'(eoi0), 32'd0);
    end
    check_eoi_eoc();
    check("acc0_ns0_sum", 32'(dout0), 32'h0040);
    drain(8'b0011_1001, 6);

    // Pass 3: overflow in namespace 1
    do_start();
    wr(2'd0, 2'd1, 16'h7FFF);
    wr(2'd0, 2'd1, 16'h0001);
    wr(2'd0, 2'd0, 16'h0005);
    wr(2'd0, 2'd3, 16'hFFFF);
    check_eoi_eoc();
    drain(8'h00, 0);

    // Pass 4: asynchronous reset in the middle of COMPUTE
    do_start();
    wr(2'd0, 2'd3, 16'h0002);
    wr(2'd0, 2'd2, 16'h0003);
    wr(2'd0, 2'd1, 16'h0004);
    wr(2'd0, 2'd0, 16'h0005);
    check("eoi0_pre_rst", 32'(eoi0), 32'd1);
    @(posedge clk);
    #1;
    check("err3_pre_rst", 32'(err3), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy0", 32'(busy0), 32'd0);
    check("arst_busy3", 32'(busy3), 32'd0);
    check("arst_err3", 32'(err3), 32'd0);
    check("arst_eoc0", 32'(eoc0), 32'd0);
    check("arst_dout0", 32'(dout0), 32'd0);
    q0.delete();
    q3.delete();
    loading = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      check("post_rst_eoc0", 32'(eoc0), 32'd0);
      check("post_rst_busy0", 32'(busy0), 32'd0);
    end

    // Pass 5: normal operation after reset
    do_start();
    wr(2'd0, 2'd2, 16'h1234);
    wr(2'd0, 2'd2, 16'h1111);
    wr(2'd0, 2'd0, 16'hA5A5);
    wr(2'd0, 2'd1, 16'h0F0F);
    check_eoi_eoc();
    drain(8'b0000_0101, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
